// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer type encoding and the arbiter's owner state.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } owner_t;

endpackage

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: the address-phase owner drives the shared bus, and
// the write-data mux follows one cycle behind so the data phase stays with its master.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [1:0][31:0] HADDR_M,
    input  logic [1:0][1:0]  HTRANS_M,
    input  logic [1:0]       HWRITE_M,
    input  logic [1:0][2:0]  HSIZE_M,
    input  logic [1:0][31:0] HWDATA_M,
    output logic [1:0]       HREADY_M,
    output logic [31:0]      HRDATA_M,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic [31:0]      HRDATA,
    output logic             HMASTER
);

    localparam owner_t RESET_OWNER = (DEFAULT_MASTER == 0) ? OWN0 : OWN1;

    owner_t  owner;
    owner_t  data_owner;
    logic    own_idx;
    logic    oth_idx;
    logic    data_idx;
    htrans_t own_trans;
    htrans_t oth_trans;
    logic    handover;

    assign own_idx   = owner;
    assign oth_idx   = ~own_idx;
    assign data_idx  = data_owner;
    assign own_trans = htrans_t'(HTRANS_M[own_idx]);
    assign oth_trans = htrans_t'(HTRANS_M[oth_idx]);

    // Bursts are never split: the owner must show IDLE before the other may take over.
    assign handover = HREADY && (own_trans == IDLE) && (oth_trans == NONSEQ);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner      <= RESET_OWNER;
            data_owner <= RESET_OWNER;
        end else begin
            if (handover) begin
                owner <= (owner == OWN0) ? OWN1 : OWN0;
            end
            if (HREADY) begin
                data_owner <= owner;
            end
        end
    end

    assign HADDR    = HADDR_M[own_idx];
    assign HTRANS   = HTRANS_M[own_idx];
    assign HWRITE   = HWRITE_M[own_idx];
    assign HSIZE    = HSIZE_M[own_idx];
    assign HMASTER  = own_idx;
    assign HWDATA   = HWDATA_M[data_idx];
    assign HRDATA_M = HRDATA;

    // NOTE: default the whole vector first so the indexed writes below cannot infer a latch.
    always_comb begin
        HREADY_M          = '0;
        HREADY_M[own_idx] = HREADY;
        // A waiting master is stalled only while it presents a real request (NONSEQ/SEQ).
        HREADY_M[oth_idx] = ~oth_trans[1];
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: the driver queues expected bus values per cycle,
// and a monitor on the falling edge pops and compares them.
module tb_ahb_master_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic             clk;
    logic             rst_n;
    logic [1:0][31:0] haddr_m;
    logic [1:0][1:0]  htrans_m;
    logic [1:0]       hwrite_m;
    logic [1:0][2:0]  hsize_m;
    logic [1:0][31:0] hwdata_m;
    logic [1:0]       hready_m;
    logic [31:0]      hrdata_m;
    logic [31:0]      haddr;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [2:0]       hsize;
    logic [31:0]      hwdata;
    logic             hready;
    logic [31:0]      hrdata;
    logic             hmaster;

    ahb_master_arbiter #(.DEFAULT_MASTER(0)) dut (
        .HCLK     (clk),
        .HRESETn  (rst_n),
        .HADDR_M  (haddr_m),
        .HTRANS_M (htrans_m),
        .HWRITE_M (hwrite_m),
        .HSIZE_M  (hsize_m),
        .HWDATA_M (hwdata_m),
        .HREADY_M (hready_m),
        .HRDATA_M (hrdata_m),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HWDATA   (hwdata),
        .HREADY   (hready),
        .HRDATA   (hrdata),
        .HMASTER  (hmaster)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {F_HMASTER, F_HTRANS, F_HADDR, F_HREADY_M, F_HWDATA, F_HRDATA_M} field_e;
    typedef struct {
        int          cyc;
        field_e      f;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] field_val(field_e f);
        case (f)
            F_HMASTER:  return {31'b0, hmaster};
            F_HTRANS:   return {30'b0, htrans};
            F_HADDR:    return haddr;
            F_HREADY_M: return {30'b0, hready_m};
            F_HWDATA:   return hwdata;
            default:    return hrdata_m;
        endcase
    endfunction

    task automatic exp_push(field_e f, logic [31:0] v, string n);
        sb.push_back('{cyc, f, v, n});
    endtask

    // Monitor: compare everything the driver queued for the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = field_val(e.f);
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int m, logic [1:0] t, logic [31:0] a, logic w, logic [31:0] d);
        htrans_m[m] = t;
        haddr_m[m]  = a;
        hwrite_m[m] = w;
        hwdata_m[m] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t got no finish expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        hready   = 1'b1;
        hrdata   = 32'h0;
        hsize_m  = {3'd2, 3'd2};
        drive(0, T_IDLE, 32'h0, 1'b0, 32'hA0A0_0000);
        drive(1, T_IDLE, 32'h0, 1'b0, 32'hB1B1_0000);

        // Reset state
        step();
        exp_push(F_HMASTER,  32'd0, "rst_hmaster");
        exp_push(F_HREADY_M, 32'd3, "rst_hready_m");
        exp_push(F_HTRANS,   32'd0, "rst_htrans");
        exp_push(F_HWDATA,   32'hA0A0_0000, "rst_hwdata");
        step();
        rst_n = 1'b1;

        // M1 single read while M0 idles
        step();
        drive(1, T_NONSEQ, 32'h2000_0010, 1'b0, 32'hB1B1_0000);
        exp_push(F_HMASTER,  32'd0, "rd_req_hmaster");
        exp_push(F_HREADY_M, 32'd1, "rd_req_stall_m1");
        exp_push(F_HTRANS,   32'd0, "rd_req_htrans");
        step();
        exp_push(F_HMASTER,  32'd1, "rd_hmaster");
        exp_push(F_HADDR,    32'h2000_0010, "rd_haddr");
        exp_push(F_HTRANS,   32'd2, "rd_htrans");
        exp_push(F_HREADY_M, 32'd3, "rd_hready_m");
        step();
        drive(1, T_IDLE, 32'h0, 1'b0, 32'hB1B1_0001);
        hready = 1'b0;
        hrdata = 32'hDEAD_BEEF;
        exp_push(F_HRDATA_M, 32'hDEAD_BEEF, "rd_hrdata_m");
        exp_push(F_HREADY_M, 32'd1, "rd_wait_hready_m");
        exp_push(F_HWDATA,   32'hB1B1_0001, "rd_dphase_hwdata");
        step();
        hready = 1'b1;
        exp_push(F_HREADY_M, 32'd3, "rd_done_hready_m");
        exp_push(F_HMASTER,  32'd1, "park_m1");

        // M0 takes the bus back for a 4-beat INCR write; M1 requests from beat 2
        step();
        drive(0, T_NONSEQ, 32'h0000_0100, 1'b1, 32'hA0A0_0000);
        exp_push(F_HMASTER,  32'd1, "m0_req_hmaster");
        exp_push(F_HREADY_M, 32'd2, "m0_req_stall_m0");
        step();
        exp_push(F_HMASTER,  32'd0, "b1_hmaster");
        exp_push(F_HADDR,    32'h0000_0100, "b1_haddr");
        exp_push(F_HTRANS,   32'd2, "b1_htrans");
        step();
        drive(0, T_SEQ, 32'h0000_0104, 1'b1, 32'hC000_0001);
        drive(1, T_NONSEQ, 32'h3000_0000, 1'b1, 32'hB1B1_0002);
        exp_push(F_HMASTER,  32'd0, "b2_hmaster");
        exp_push(F_HADDR,    32'h0000_0104, "b2_haddr");
        exp_push(F_HREADY_M, 32'd1, "b2_stall_m1");
        exp_push(F_HWDATA,   32'hC000_0001, "b2_hwdata");
        step();
        drive(0, T_SEQ, 32'h0000_0108, 1'b1, 32'hC000_0002);
        exp_push(F_HMASTER,  32'd0, "b3_hmaster");
        exp_push(F_HTRANS,   32'd3, "b3_htrans");
        exp_push(F_HREADY_M, 32'd1, "b3_stall_m1");
        step();
        drive(0, T_SEQ, 32'h0000_010C, 1'b1, 32'hC000_0003);
        exp_push(F_HMASTER,  32'd0, "b4_hmaster");
        exp_push(F_HADDR,    32'h0000_010C, "b4_haddr");
        exp_push(F_HREADY_M, 32'd1, "b4_stall_m1");
        step();
        drive(0, T_IDLE, 32'h0, 1'b0, 32'hC000_0004);
        exp_push(F_HMASTER,  32'd0, "burst_idle_hmaster");
        exp_push(F_HTRANS,   32'd0, "burst_idle_htrans");
        exp_push(F_HREADY_M, 32'd1, "burst_idle_stall_m1");
        step();
        exp_push(F_HMASTER,  32'd1, "ho_m1_hmaster");
        exp_push(F_HADDR,    32'h3000_0000, "ho_m1_haddr");
        exp_push(F_HWDATA,   32'hC000_0004, "ho_m1_last_wdata");

        // M1 write data phase stretched by wait states while M0 requests
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1, T_IDLE, 32'h0, 1'b0, 32'hB1B1_0003);
            drive(0, T_NONSEQ, 32'h0000_0200, 1'b0, 32'hA0A0_00F0 + i);
            hready = 1'b0;
            exp_push(F_HMASTER,  32'd1, "wait_hmaster");
            exp_push(F_HWDATA,   32'hB1B1_0003, "wait_hwdata");
            exp_push(F_HREADY_M, 32'd0, "wait_hready_m");
        end
        step();
        hready = 1'b1;
        exp_push(F_HMASTER,  32'd1, "wait_end_hmaster");
        exp_push(F_HWDATA,   32'hB1B1_0003, "wait_end_hwdata");
        exp_push(F_HREADY_M, 32'd2, "wait_end_hready_m");
        step();
        exp_push(F_HMASTER,  32'd0, "ho_m0_hmaster");
        exp_push(F_HADDR,    32'h0000_0200, "ho_m0_haddr");

        // Both request from park at M0, then single transfers alternate
        step();
        drive(0, T_IDLE, 32'h0, 1'b0, 32'hA0A0_0000);
        exp_push(F_HMASTER, 32'd0, "park_m0");
        step();
        drive(0, T_NONSEQ, 32'h0000_0A00, 1'b0, 32'hA0A0_0000);
        drive(1, T_NONSEQ, 32'h3000_0B00, 1'b0, 32'hB1B1_0000);
        exp_push(F_HMASTER,  32'd0, "rr0_hmaster");
        exp_push(F_HADDR,    32'h0000_0A00, "rr0_haddr");
        exp_push(F_HREADY_M, 32'd1, "rr0_hready_m");
        step();
        drive(0, T_IDLE, 32'h0, 1'b0, 32'hA0A0_0000);
        exp_push(F_HMASTER, 32'd0, "rr0_idle_hmaster");
        step();
        drive(0, T_NONSEQ, 32'h0000_0A04, 1'b0, 32'hA0A0_0000);
        exp_push(F_HMASTER,  32'd1, "rr1_hmaster");
        exp_push(F_HADDR,    32'h3000_0B00, "rr1_haddr");
        exp_push(F_HREADY_M, 32'd2, "rr1_hready_m");
        step();
        drive(1, T_IDLE, 32'h0, 1'b0, 32'hB1B1_0000);
        exp_push(F_HMASTER, 32'd1, "rr1_idle_hmaster");
        step();
        drive(1, T_NONSEQ, 32'h3000_0B04, 1'b0, 32'hB1B1_0000);
        exp_push(F_HMASTER, 32'd0, "rr2_hmaster");
        exp_push(F_HADDR,   32'h0000_0A04, "rr2_haddr");
        step();
        drive(0, T_IDLE, 32'h0, 1'b0, 32'hA0A0_0000);
        exp_push(F_HMASTER, 32'd0, "rr2_idle_hmaster");
        step();
        exp_push(F_HMASTER, 32'd1, "rr3_hmaster");
        exp_push(F_HADDR,   32'h3000_0B04, "rr3_haddr");

        // Reset in the middle of an M1 burst
        step();
        drive(1, T_SEQ, 32'h3000_0B08, 1'b1, 32'hB1B1_0010);
        exp_push(F_HMASTER, 32'd1, "mid_burst_hmaster");
        step();
        drive(1, T_SEQ, 32'h3000_0B0C, 1'b1, 32'hB1B1_0011);
        drive(0, T_IDLE, 32'h0000_0CC0, 1'b0, 32'hA0A0_0CC0);
        rst_n = 1'b0;
        exp_push(F_HMASTER,  32'd0, "rst_mid_hmaster");
        exp_push(F_HWDATA,   32'hA0A0_0CC0, "rst_mid_hwdata");
        exp_push(F_HADDR,    32'h0000_0CC0, "rst_mid_haddr");
        exp_push(F_HREADY_M, 32'd1, "rst_mid_hready_m");
        step();
        drive(1, T_IDLE, 32'h0, 1'b0, 32'hB1B1_0012);
        rst_n = 1'b1;
        step();
        exp_push(F_HMASTER, 32'd0, "post_rst_hmaster");
        exp_push(F_HWDATA,  32'hA0A0_0CC0, "post_rst_hwdata");

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 Parameter SHALL be: DEFAULT_MASTER, 0, master index (0 or 1) owning the bus after reset and parked when nobody requests.
REQ-002 Ports SHALL be, clock and reset first:
 HCLK  input  1  single bus clock, all state on rising edge
 HRESETn  input  1  asynchronous active-low reset
 HADDR_M  input  [1:0][31:0]  per-master address
 HTRANS_M  input  [1:0][1:0]  per-master transfer type
 HWRITE_M  input  [1:0]  per-master write flag
 HSIZE_M  input  [1:0][2:0]  per-master size
 HWDATA_M  input  [1:0][31:0]  per-master write data
 HREADY_M  output  [1:0]  per-master ready
 HRDATA_M  output  32  read data, broadcast to both masters
 HADDR, HTRANS, HWRITE, HSIZE, HWDATA  output  32/2/1/3/32  muxed master signals to interconnect
 HREADY  input  1  ready from interconnect
 HRDATA  input  32  read data from interconnect
 HMASTER  output  1  current address-phase owner

Function
REQ-003 Block SHALL share one AHB-Lite interconnect between two masters (0 = CPU, 1 = DMA/capture) with 2-state FSM OWN0/OWN1 held in register owner.
REQ-004 Address-phase outputs (HADDR, HTRANS, HWRITE, HSIZE) SHALL be combinational copies of the owner's inputs; HMASTER = owner.
REQ-005 Register data_owner SHALL load owner on every rising edge with HREADY=1 and hold otherwise; HWDATA SHALL be HWDATA_M[data_owner].
REQ-006 HRDATA_M SHALL equal HRDATA, no register.
REQ-007 HREADY_M[owner] SHALL equal HREADY.
REQ-008 HREADY_M[non-owner] SHALL be 1 when its HTRANS_M is IDLE or BUSY, 0 when NONSEQ or SEQ; stalled master holds its address phase per AHB-Lite.
REQ-009 Handover SHALL occur at a rising edge only when HREADY=1, owner's HTRANS_M is IDLE and non-owner's HTRANS_M is NONSEQ; owner flips at that edge.
REQ-010 No handover SHALL occur while owner drives NONSEQ, SEQ or BUSY (bursts never split); masters must insert IDLE to release.
REQ-011 Owner idle with no request from the other SHALL keep ownership (park).
REQ-012 Handover SHALL cost exactly one cycle: the old owner's IDLE address phase, then the new owner's NONSEQ on the bus in the next cycle.
REQ-013 HREADY=0 at the candidate edge SHALL defer handover; owner and data_owner hold.
REQ-014 Both masters requesting from park SHALL let the parked owner proceed; the other waits until the owner drives IDLE with HREADY=1.
REQ-015 Two masters ping-ponging IDLE/NONSEQ SHALL alternate ownership on each qualifying edge (round-robin for two).

Reset
REQ-016 HRESETn low SHALL asynchronously set owner = data_owner = DEFAULT_MASTER.
REQ-017 During and after reset, outputs SHALL follow REQ-004..008 combinationally from that state: HMASTER = DEFAULT_MASTER, HWDATA = HWDATA_M[DEFAULT_MASTER].
REQ-018 Reset mid-burst or mid-handover SHALL abandon the transfer with no further state retained.

Structure
REQ-019 Shared package ahb_pkg SHALL hold htrans_t (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11) and the owner state enum.
REQ-020 Block SHALL be one module with no sub-modules; it instantiates between masters and the existing interconnect unchanged.

Verification
REQ-021 Reset with DEFAULT_MASTER=0, both IDLE -> HMASTER=0, HREADY_M=2'b11, HTRANS=IDLE.
REQ-022 M0 idle, M1 NONSEQ read 0x2000_0010, HREADY=1 -> next cycle HMASTER=1, HADDR=0x2000_0010, HREADY_M[1] follows HREADY, read data reaches HRDATA_M.
REQ-023 M0 4-beat INCR write from 0x0000_0100 with M1 NONSEQ pending from beat 2 -> all 4 beats on bus, HREADY_M[1]=0 throughout, handover only after M0 IDLE.
REQ-024 M1 owns, data phase held 3 cycles by HREADY=0, M0 requests -> owner and data_owner frozen until HREADY=1; HWDATA stays HWDATA_M[1] to end of data phase.
REQ-025 Both NONSEQ from park at M0 -> M0 first; alternating single transfers then alternate HMASTER 0,1,0,1.
REQ-026 HRESETn low mid-burst with owner=1 -> HMASTER=0 immediately, HWDATA=HWDATA_M[0].
